// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared VGA 640x480@60 timing constants, the 16-entry text palette,
//   the background colour and the stage-1 pipeline record used by
//   vga_text_render.
package vga_pkg;

    // Horizontal timing in pixel ticks (the active width is a module parameter).
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = 800;

    // Vertical timing in lines.
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = 525;

    localparam logic [11:0] BG_COLOR = 12'h000;

    // CGA-style palette, {R,G,B} nibbles. The list is written from index 15
    // down to index 0, so PALETTE[i] gives entry i.
    localparam logic [15:0][11:0] PALETTE = {
        12'hFFF, 12'hFF5, 12'hF5F, 12'hF55,   // 15..12
        12'h5FF, 12'h5F5, 12'h55F, 12'h555,   // 11..8
        12'hAAA, 12'hA50, 12'hA0A, 12'hA00,   //  7..4
        12'h0AA, 12'h0A0, 12'h00A, 12'h000    //  3..0
    };

    // Everything stage 1 captures about one pixel except the font address,
    // which leaves the block as a port.
    typedef struct packed {
        logic [3:0] color;     // palette index
        logic       dp;        // inside the glyph cell
        logic [2:0] x_lsb;     // column within the 8-pixel glyph row
        logic       video_on;  // pixel lies in the visible area
        logic       hs;        // raw hsync, active low
        logic       vs;        // raw vsync, active low
    } s1_t;

    // Reset value of the stage-1 record: blanked, syncs inactive.
    localparam s1_t S1_RST = '{color: 4'd0, dp: 1'b0, x_lsb: 3'd0,
                               video_on: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   Pixel-clock divider, horizontal and vertical counters, raw (not yet
//   pipelined) sync pulses and the visible-area flag.
// Ports:
//   clk, reset_n  - system clock, asynchronous active-low reset
//   pixel_tick    - one-clk pulse every 4 clks (divider == 3)
//   h_count       - 0..H_TOTAL-1, advances on pixel_tick
//   v_count       - 0..V_TOTAL-1, advances when h_count wraps
//   hsync_raw     - low for h_count in the horizontal sync window
//   vsync_raw     - low for v_count in the vertical sync window
//   video_on      - high inside the H_ACTIVE x V_ACTIVE visible area
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       pixel_tick,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       video_on
);

    // Sync windows derived from the timing constants: 656..751 and 490..491
    // at the default resolution.
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    logic [1:0] div;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) div <= 2'd0;
        else          div <= div + 2'd1;
    end

    // Decoded directly from the divider, so it is 0 during reset and first
    // rises on the 4th clock after release.
    assign pixel_tick = (div == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_count <= 10'd0;
            v_count <= 10'd0;
        end else if (pixel_tick) begin
            if (h_count == 10'(H_TOTAL - 1)) begin
                h_count <= 10'd0;
                // The frame wrap happens in the same tick as the line wrap.
                if (v_count == 10'(V_TOTAL - 1)) v_count <= 10'd0;
                else                             v_count <= v_count + 10'd1;
            end else begin
                h_count <= h_count + 10'd1;
            end
        end
    end

    assign hsync_raw = !((h_count >= 10'(HS_START)) && (h_count <= 10'(HS_END)));
    assign vsync_raw = !((v_count >= 10'(VS_START)) && (v_count <= 10'(VS_END)));
    assign video_on  = (h_count < 10'(H_ACTIVE)) && (v_count < 10'(V_ACTIVE));

endmodule

// File: rtl/vga_text_render.sv
// vga_text_render
//   Text-mode VGA back end. It drives pixel_x/pixel_y to an external
//   character generator, forwards the generator's glyph address to a
//   synchronous font ROM and turns the returned glyph row into a 12-bit
//   colour, with hsync/vsync delayed to stay aligned with the colour.
// Ports:
//   clk, reset_n      - system clock, asynchronous active-low reset
//   pixel_x, pixel_y  - current beam position (the raw counters)
//   rom_addr          - {char code, glyph row} from the character generator
//   color_addr        - palette index for the current glyph
//   dp                - 1 inside the glyph area, 0 for background
//   font_addr         - registered address to the font ROM
//   font_data         - glyph row from the ROM, bit 7 = leftmost pixel
//   hsync, vsync      - active-low syncs, aligned with rgb
//   rgb               - {R,G,B} pixel colour
//   pixel_tick        - one-clk pulse every 4 clks
//
// Pipeline (every register loads only on pixel_tick):
//   tick n   : pixel (x,y) is on pixel_x/pixel_y; stage 1 captures the
//              ROM address plus the per-pixel attributes.
//   tick n+1 : font_data now holds the addressed row; stage 2 picks this
//              pixel's bit and registers rgb/hsync/vsync.
//   rgb and the syncs for (x,y) are therefore visible while pixel_x shows
//   x+2, which is 8 clks behind the counters.
module vga_text_render
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    input  logic [10:0] rom_addr,
    input  logic [3:0]  color_addr,
    input  logic        dp,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        pixel_tick
);

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       hs_raw;
    logic       vs_raw;
    logic       video_on;

    vga_sync_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .pixel_tick (pixel_tick),
        .h_count    (h_count),
        .v_count    (v_count),
        .hsync_raw  (hs_raw),
        .vsync_raw  (vs_raw),
        .video_on   (video_on)
    );

    assign pixel_x = h_count;
    assign pixel_y = v_count;

    // ---------------- stage 1 ----------------
    s1_t s1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            font_addr <= 11'd0;
            s1        <= S1_RST;
        end else if (pixel_tick) begin
            font_addr   <= rom_addr;
            s1.color    <= color_addr;
            s1.dp       <= dp;
            s1.x_lsb    <= h_count[2:0];
            s1.video_on <= video_on;
            s1.hs       <= hs_raw;
            s1.vs       <= vs_raw;
        end
    end

    // ---------------- stage 2 ----------------
    // font_data is the row addressed by font_addr, which belongs to the
    // pixel now held in stage 1; bit 7 is the leftmost column.
    logic        glyph_bit;
    logic [11:0] rgb_nxt;

    assign glyph_bit = font_data[3'd7 - s1.x_lsb];

    always_comb begin
        rgb_nxt = 12'h000;
        // Outside the visible area the output is forced to black no matter
        // what dp or the ROM say.
        if (s1.video_on)
            rgb_nxt = (s1.dp && glyph_bit) ? PALETTE[s1.color] : BG_COLOR;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb   <= 12'h000;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pixel_tick) begin
            rgb   <= rgb_nxt;
            hsync <= s1.hs;
            vsync <= s1.vs;
        end
    end

endmodule

// File: tb/tb_vga_text_render.sv
// tb_vga_text_render
//   Directed, table-driven bench for vga_text_render. The bench acts as the
//   character generator and the font ROM. A reference beam position plus a
//   three-deep pixel history (current / stage 1 / output) supplies the
//   expected pixel_x/y, font_addr, rgb and syncs on every clock. Table
//   entries carry hand-computed rgb values for chosen pixels. Pixels that
//   are not in the table get dp = 0 with font_data = 8'hFF, so the expected
//   colour there is black. Long stretches of the frame are skipped by
//   loading the counters directly.
module tb_vga_text_render;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  pixel_x, pixel_y;
    logic [10:0] rom_addr;
    logic [3:0]  color_addr;
    logic        dp;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic        hsync, vsync;
    logic [11:0] rgb;
    logic        pixel_tick;

    always #5 clk = ~clk;

    vga_text_render #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .rom_addr   (rom_addr),
        .color_addr (color_addr),
        .dp         (dp),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .pixel_tick (pixel_tick)
    );

    typedef struct {
        int          x;
        int          y;
        logic [10:0] rom;
        logic        dp;
        logic [3:0]  color;
        logic [7:0]  font;
        logic [11:0] exp_rgb;
    } vec_t;

    typedef struct {
        int          h;
        int          v;
        logic [10:0] rom;
        logic        dp;
        logic [3:0]  color;
        logic [7:0]  font;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        int          idx;
    } pix_t;

    localparam int NV = 18;
    vec_t vecs [NV];
    int   hits [NV];

    int   n_chk = 0;
    int   n_fail = 0;
    int   div_ref, ref_h, ref_v;
    pix_t cur, s1, s2;
    logic [9:0] jh, jv;

    bit   mon_h, mon_v;
    int   hs_low, hs_first, vs_low, vs_first_h, vs_first_v;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: actual %0h required %0h (beam %0d,%0d t=%0t)",
                         nm, act, exp, ref_h, ref_v, $time);
        end
    endtask

    function automatic pix_t rst_pix();
        pix_t p;
        p.h = -1; p.v = -1; p.rom = 11'd0; p.dp = 1'b0; p.color = 4'd0;
        p.font = 8'hFF; p.rgb = 12'h000; p.hs = 1'b1; p.vs = 1'b1; p.idx = -1;
        return p;
    endfunction

    // Stimulus and expected output for one pixel. The sync windows are
    // written as plain numbers (656..751, 490..491).
    function automatic pix_t make_pix(input int h, input int v);
        pix_t p;
        p.h = h; p.v = v; p.idx = -1;
        p.rom = {h[6:0], v[3:0]};
        p.dp = 1'b0; p.color = h[3:0]; p.font = 8'hFF; p.rgb = 12'h000;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].x == h && vecs[i].y == v) begin
                p.rom = vecs[i].rom; p.dp = vecs[i].dp; p.color = vecs[i].color;
                p.font = vecs[i].font; p.rgb = vecs[i].exp_rgb; p.idx = i;
            end
        end
        p.hs = !(h >= 656 && h <= 751);
        p.vs = !(v >= 490 && v <= 491);
        return p;
    endfunction

    // The ROM row for a pixel arrives one tick after its address, so
    // font_data follows the pixel now in stage 1.
    task automatic apply_inputs();
        rom_addr   = cur.rom;
        color_addr = cur.color;
        dp         = cur.dp;
        font_data  = s1.font;
    endtask

    task automatic step();
        @(posedge clk);
        if (div_ref == 3) begin
            s2 = s1;
            s1 = cur;
            if (ref_h == 799) begin
                ref_h = 0;
                ref_v = (ref_v == 524) ? 0 : ref_v + 1;
            end else begin
                ref_h++;
            end
        end
        div_ref = (div_ref + 1) % 4;
        #1;
        if (div_ref == 0) begin
            cur = make_pix(ref_h, ref_v);
            apply_inputs();
            if (mon_h && hsync === 1'b0) begin
                if (hs_low == 0) hs_first = ref_h;
                hs_low++;
            end
            if (mon_v && vsync === 1'b0) begin
                if (vs_low == 0) begin vs_first_h = ref_h; vs_first_v = ref_v; end
                vs_low++;
            end
        end
        chk("pixel_x", pixel_x, ref_h);
        chk("pixel_y", pixel_y, ref_v);
        chk("pixel_tick", pixel_tick, (div_ref == 3));
        chk("font_addr", font_addr, s1.rom);
        chk($sformatf("rgb[%0d,%0d]", s2.h, s2.v), rgb, s2.rgb);
        chk($sformatf("hsync[%0d,%0d]", s2.h, s2.v), hsync, s2.hs);
        chk($sformatf("vsync[%0d,%0d]", s2.h, s2.v), vsync, s2.vs);
        if (s2.idx >= 0) hits[s2.idx]++;
    endtask

    task automatic run_ticks(input int n);
        repeat (n * 4) step();
    endtask

    // Call right after a tick: loads the counters with (h,v) and runs one
    // full tick, so it returns at (h+1,v) with the divider back at 0.
    task automatic jump(input int h, input int v);
        jh = 10'(h); jv = 10'(v);
        force dut.u_sync.h_count = jh;
        force dut.u_sync.v_count = jv;
        ref_h = h; ref_v = v;
        cur = make_pix(h, v);
        apply_inputs();
        step();
        release dut.u_sync.h_count;
        release dut.u_sync.v_count;
        repeat (3) step();
    endtask

    task automatic restart_model();
        div_ref = 0; ref_h = 0; ref_v = 0;
        s1 = rst_pix(); s2 = rst_pix();
        cur = make_pix(0, 0);
        apply_inputs();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rgb"}, rgb, 12'h000);
        chk({tag, "_hsync"}, hsync, 1'b1);
        chk({tag, "_vsync"}, vsync, 1'b1);
        chk({tag, "_tick"}, pixel_tick, 1'b0);
        chk({tag, "_px"}, pixel_x, 10'd0);
        chk({tag, "_py"}, pixel_y, 10'd0);
        chk({tag, "_faddr"}, font_addr, 11'd0);
    endtask

    initial begin
        //           x    y    rom      dp    col    font    rgb
        vecs[0]  = '{8,   0,   11'h081, 1'b1, 4'd2,  8'h80, 12'h0A0};
        vecs[1]  = '{9,   0,   11'h081, 1'b1, 4'd2,  8'h80, 12'h000};
        vecs[2]  = '{10,  0,   11'h081, 1'b1, 4'd2,  8'h80, 12'h000};
        vecs[3]  = '{11,  0,   11'h081, 1'b1, 4'd2,  8'h80, 12'h000};
        vecs[4]  = '{12,  0,   11'h081, 1'b1, 4'd2,  8'h80, 12'h000};
        vecs[5]  = '{13,  0,   11'h081, 1'b1, 4'd2,  8'h80, 12'h000};
        vecs[6]  = '{14,  0,   11'h081, 1'b1, 4'd2,  8'h80, 12'h000};
        vecs[7]  = '{15,  0,   11'h081, 1'b1, 4'd2,  8'h80, 12'h000};
        vecs[8]  = '{16,  0,   11'h2A0, 1'b1, 4'd15, 8'h01, 12'h000};
        vecs[9]  = '{23,  0,   11'h2A0, 1'b1, 4'd15, 8'h01, 12'hFFF};
        vecs[10] = '{24,  0,   11'h350, 1'b0, 4'd0,  8'hFF, 12'h000};
        vecs[11] = '{100, 0,   11'h111, 1'b0, 4'd2,  8'hFF, 12'h000};
        vecs[12] = '{101, 0,   11'h111, 1'b1, 4'd5,  8'hFF, 12'hA0A};
        vecs[13] = '{700, 0,   11'h222, 1'b1, 4'd7,  8'hFF, 12'h000};
        vecs[14] = '{398, 300, 11'h333, 1'b1, 4'd12, 8'hFF, 12'hF55};
        vecs[15] = '{0,   0,   11'h044, 1'b1, 4'd1,  8'hFF, 12'h00A};
        vecs[16] = '{639, 479, 11'h555, 1'b1, 4'd14, 8'hFF, 12'hFF5};
        vecs[17] = '{640, 479, 11'h555, 1'b1, 4'd14, 8'hFF, 12'h000};
        for (int i = 0; i < NV; i++) hits[i] = 0;
        mon_h = 0; mon_v = 0;
        hs_low = 0; hs_first = -1; vs_low = 0; vs_first_h = -1; vs_first_v = -1;
        div_ref = 0; ref_h = 0; ref_v = 0;

        // Reset with busy inputs: everything must sit at its reset value.
        reset_n = 1'b0;
        rom_addr = 11'h7FF; color_addr = 4'hF; dp = 1'b1; font_data = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");

        // Release just after an edge; the first tick lands on the 4th clock.
        reset_n = 1'b1;
        restart_model();

        // Line 0 and into line 1: glyph vectors, blanking, font_addr
        // forwarding, and the hsync window length and position.
        mon_h = 1;
        run_ticks(810);
        mon_h = 0;
        chk("hsync_low_ticks", hs_low, 96);
        chk("hsync_first_seen_h", hs_first, 658);

        // Last visible pixel of the frame and the first blank pixel after it.
        jump(636, 479);
        run_ticks(8);

        // Vertical sync: two full lines low, first seen for pixel (0,490).
        jump(790, 489);
        mon_v = 1;
        run_ticks(2400);
        mon_v = 0;
        chk("vsync_low_ticks", vs_low, 1600);
        chk("vsync_first_seen_h", vs_first_h, 2);
        chk("vsync_first_seen_v", vs_first_v, 490);

        // Frame wrap (799,524) -> (0,0) in a single tick.
        jump(796, 524);
        run_ticks(3);
        chk("wrap_x", pixel_x, 10'd0);
        chk("wrap_y", pixel_y, 10'd0);
        run_ticks(4);

        // Mid-frame asynchronous reset while a coloured pixel is displayed.
        jump(397, 300);
        run_ticks(2);
        chk("pre_reset_rgb", rgb, 12'hF55);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk); @(posedge clk);
        #1;
        chk_reset_outputs("held_reset");
        reset_n = 1'b1;
        restart_model();
        run_ticks(12);

        // Every table entry must have reached the output and been compared.
        for (int i = 0; i < NV; i++)
            chk($sformatf("vec%0d_reached", i), (hits[i] > 0), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_text_render.md
VGA_TEXT_RENDER -- requirements
Module: vga_text_render

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-003 SHALL have port clk  input  1: 100 MHz system clock, all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port pixel_x  output  10: current horizontal count, fed to the character generator.
REQ-006 SHALL have port pixel_y  output  10: current vertical count, fed to the character generator.
REQ-007 SHALL have port rom_addr  input  11: {char code[6:0], row[3:0]} from the character generator.
REQ-008 SHALL have port color_addr  input  4: palette index for the current glyph.
REQ-009 SHALL have port dp  input  1: 1 = glyph pixel area, 0 = background.
REQ-010 SHALL have port font_addr  output  11: address to the synchronous font ROM.
REQ-011 SHALL have port font_data  input  8: ROM row, bit 7 = leftmost pixel; valid one pixel tick after font_addr.
REQ-012 SHALL have port hsync  output  1: active-low horizontal sync.
REQ-013 SHALL have port vsync  output  1: active-low vertical sync.
REQ-014 SHALL have port rgb  output  12: {R[3:0],G[3:0],B[3:0]} pixel colour.
REQ-015 SHALL have port pixel_tick  output  1: one-clk pulse every 4 clks.

Function
REQ-016 SHALL generate pixel_tick with a 2-bit free-running divider, high when divider = 3.
REQ-017 SHALL advance h_count 0..799 on each pixel_tick, wrap 799 -> 0, and increment v_count 0..524 on that wrap, v_count 524 -> 0.
REQ-018 SHALL drive pixel_x = h_count and pixel_y = v_count directly from the counter registers.
REQ-019 SHALL compute raw hsync low for h_count 656..751, raw vsync low for v_count 490..491, and video_on = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
REQ-020 SHALL use pipeline stage 1, on pixel_tick: register font_addr <= rom_addr, and capture color_addr, dp, h_count[2:0], video_on, raw hsync and raw vsync.
REQ-021 SHALL use pipeline stage 2, on the next pixel_tick: select bit = font_data[7 - x_lsb], and register rgb, hsync and vsync from the stage-1 values.
REQ-022 SHALL set rgb = PALETTE[color] when video_on && dp && bit, else BG_COLOR (12'h000) when video_on, else 12'h000.
REQ-023 SHALL present rgb/hsync/vsync for pixel (x,y) exactly 2 pixel ticks (8 clks) after pixel_x/pixel_y show (x,y), with sync and colour mutually aligned.
REQ-024 SHALL hold all pipeline registers between pixel_ticks; no output changes except on a pixel_tick edge, apart from reset.
REQ-025 SHALL force rgb = 0 when video_on = 0 regardless of dp or font_data (blanking).
REQ-026 SHALL handle simultaneous h-wrap and v-wrap (799,524) -> (0,0) in a single tick.

Reset
REQ-027 SHALL, while reset_n = 0, clear divider, h_count, v_count, font_addr and all pipeline registers, and drive rgb = 0, hsync = 1, vsync = 1, pixel_tick = 0.
REQ-028 SHALL, after reset_n deasserts mid-frame, restart at (0,0), with the first pixel_tick 4 clks after release.

Structure
REQ-029 SHALL take timing constants (H_FP/H_SYNC/H_BP/H_TOTAL, V_FP/V_SYNC/V_BP/V_TOTAL), the 16-entry PALETTE and BG_COLOR from shared package vga_pkg.
REQ-030 SHALL place counters and raw syncs in sub-module vga_sync_gen; vga_text_render SHALL instantiate it and own the pipeline.

Verification
REQ-031 SHALL check: release reset, run 1 frame -> 800 ticks/line, 525 lines/frame; hsync low 96 ticks starting at h = 656 (delayed 2 ticks); vsync low 2 lines at v = 490..491.
REQ-032 SHALL check: dp = 1, color_addr = 2, font_data = 8'b1000_0000 at pixel (8,0) -> rgb = PALETTE[2] only for x = 8, 8 clks later; x = 9..15 -> 12'h000.
REQ-033 SHALL check: dp = 0, font_data = 8'hFF, h = 100 -> rgb = BG_COLOR; at h = 700 (blank) with dp = 1 -> rgb = 0.
REQ-034 SHALL check: rom_addr = 11'h350 applied while pixel_x = 24 -> font_addr = 11'h350 after the next pixel_tick.
REQ-035 SHALL check: reset_n pulsed low at (400,300) -> outputs at reset values immediately (async); counters restart at (0,0).
REQ-036 SHALL check: counters at (799,524) -> next tick (0,0), and vsync/hsync stay consistent across the frame boundary.
